// File: rtl/aste_pkg.sv
// aste_pkg: shared constants and types for the asteroid-memory scanner.
//   - width constants for the 16-entry asteroid memory
//   - entry field offsets: entry = {x, y, dir}
//   - EMPTY_ENTRY: the all-zero word that marks an unoccupied slot
//   - aste_state_t: scanner FSM states. CLEAR is present only when
//     ASTE_CLEAR_ON_HIT_EN is defined.
package aste_pkg;

    localparam int ASTE_N_ENTRIES = 16;
    localparam int ASTE_ADDR_W    = 4;
    localparam int ASTE_COORD_W   = 4;
    localparam int ASTE_DIR_W     = 2;
    localparam int ENTRY_W        = 2*ASTE_COORD_W + ASTE_DIR_W;

    localparam int X_LSB   = 6;
    localparam int Y_LSB   = 2;
    localparam int DIR_LSB = 0;

    localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = '0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCAN,
        DONE
`ifdef ASTE_CLEAR_ON_HIT_EN
        , CLEAR
`endif
    } aste_state_t;

endpackage

// File: rtl/aste_entry_match.sv
// aste_entry_match: combinational unpack/compare of one asteroid entry.
// Ports:
//   entry    in   raw memory word {x, y, dir}
//   tgt_x    in   target column
//   tgt_y    in   target row
//   occupied out  entry is not EMPTY_ENTRY
//   match    out  occupied and (x, y) equals the target; dir is ignored
module aste_entry_match import aste_pkg::*; (
    input  logic [ENTRY_W-1:0]      entry,
    input  logic [ASTE_COORD_W-1:0] tgt_x,
    input  logic [ASTE_COORD_W-1:0] tgt_y,
    output logic                    occupied,
    output logic                    match
);

    logic [ASTE_COORD_W-1:0] x;
    logic [ASTE_COORD_W-1:0] y;

    assign x        = entry[X_LSB +: ASTE_COORD_W];
    assign y        = entry[Y_LSB +: ASTE_COORD_W];
    // An all-zero word is an empty slot, so (0,0) with dir 0 never matches.
    assign occupied = (entry != EMPTY_ENTRY);
    assign match    = occupied && (x == tgt_x) && (y == tgt_y);

endmodule

// File: rtl/aste_scanner.sv
// aste_scanner: walks every slot of the asteroid memory after a start pulse,
// counts occupied slots and reports the lowest-index slot whose (x, y) equals
// the latched target.
// Memory port: registered address, read data valid one cycle later.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            one-cycle scan request (ignored while busy)
//   target_x/y       target, latched when start is accepted
//   mem_addr/we/data memory address / write enable / write data
//   mem_q            memory read data
//   busy, done       scan in progress / one-cycle end-of-scan pulse
//   hit, hit_addr    any match / lowest matching index (held after done)
//   active_count     occupied slot count (held after done)
// Build option: ASTE_CLEAR_ON_HIT_EN adds a CLEAR cycle after a scan with a
// hit that writes zero to hit_addr, destroying the asteroid.
module aste_scanner import aste_pkg::*; #(
    parameter int N_ENTRIES = ASTE_N_ENTRIES,
    parameter int ADDR_W    = ASTE_ADDR_W,
    parameter int COORD_W   = ASTE_COORD_W,
    parameter int DIR_W     = ASTE_DIR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [COORD_W-1:0]             target_x,
    input  logic [COORD_W-1:0]             target_y,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           mem_we,
    output logic [2*COORD_W+DIR_W-1:0]     mem_data,
    input  logic [2*COORD_W+DIR_W-1:0]     mem_q,
    output logic                           busy,
    output logic                           done,
    output logic                           hit,
    output logic [ADDR_W-1:0]              hit_addr,
    output logic [$clog2(N_ENTRIES+1)-1:0] active_count
);

    localparam int CNT_W = $clog2(N_ENTRIES+1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ENTRIES-1);

    aste_state_t         state_q, state_d;
    logic [COORD_W-1:0]  tgt_x_q, tgt_y_q;
    logic [ADDR_W-1:0]   addr_q;    // address presented to memory
    logic [ADDR_W-1:0]   idx_q;     // index of the entry now on mem_q
    logic                hit_q;
    logic [ADDR_W-1:0]   hit_addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                occupied, match;

    aste_entry_match u_match (
        .entry    (mem_q),
        .tgt_x    (tgt_x_q),
        .tgt_y    (tgt_y_q),
        .occupied (occupied),
        .match    (match)
    );

    // The only write ever issued is a clear, so write data is always zero.
    assign mem_data     = '0;
    assign hit          = hit_q;
    assign hit_addr     = hit_addr_q;
    assign active_count = cnt_q;

    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = addr_q;
        case (state_q)
            IDLE:  if (start) state_d = FETCH;
            FETCH: begin
                busy    = 1'b1;
                state_d = SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (idx_q == LAST_IDX) begin
`ifdef ASTE_CLEAR_ON_HIT_EN
                    // Include this cycle's match: hit_q lags by one entry.
                    state_d = (hit_q || match) ? CLEAR : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef ASTE_CLEAR_ON_HIT_EN
            CLEAR: begin
                busy     = 1'b1;
                // Gate with reset so a reset in this cycle cannot land a write.
                mem_we   = !reset;
                mem_addr = hit_addr_q;
                state_d  = DONE;
            end
`endif
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tgt_x_q    <= '0;
            tgt_y_q    <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            hit_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    tgt_x_q    <= target_x;
                    tgt_y_q    <= target_y;
                    addr_q     <= '0;
                    hit_q      <= 1'b0;
                    hit_addr_q <= '0;
                    cnt_q      <= '0;
                end
                FETCH: begin
                    addr_q <= addr_q + 1'b1;
                    idx_q  <= '0;
                end
                SCAN: begin
                    // Last cycle's address wraps; park it at 0 for idle.
                    addr_q <= (idx_q == LAST_IDX) ? '0 : addr_q + 1'b1;
                    idx_q  <= idx_q + 1'b1;
                    if (occupied) cnt_q <= cnt_q + CNT_W'(1);
                    if (match && !hit_q) begin
                        hit_q      <= 1'b1;
                        hit_addr_q <= idx_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
